// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates in program order at the tail, captures CDB results
// out of order, and commits at most one ready entry per cycle from the head.
module reorder_buffer #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic             alloc_writes,
    input  logic [4:0]       alloc_dest,
    input  logic             alloc_is_branch,
    input  logic [31:0]      alloc_pc,
    input  logic [31:0]      alloc_imm_se,
    input  logic             alloc_pred_taken,
    output logic [TAG_W-1:0] ROB_entry,
    output logic             full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             cdb_taken,
    input  logic             mispredicted,
    output logic [TAG_W:0]   count,
    output logic             RegWrite,
    output logic [4:0]       rd,
    output logic [31:0]      WriteData,
    output logic [TAG_W-1:0] commit_tag,
    output logic             valid_in,
    output logic             committed_is_branch,
    output logic [31:0]      committed_pc,
    output logic [31:0]      commit_imm_se,
    output logic             commit_taken,
    output logic             commit_result
);

    localparam logic [TAG_W:0]   DEPTH_C = (TAG_W + 1)'(DEPTH);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W + 1)'(1);

    logic             busy_r       [DEPTH];
    logic             ready_r      [DEPTH];
    logic             writes_r     [DEPTH];
    logic [4:0]       dest_r       [DEPTH];
    logic             is_branch_r  [DEPTH];
    logic [31:0]      pc_r         [DEPTH];
    logic [31:0]      imm_se_r     [DEPTH];
    logic             pred_taken_r [DEPTH];
    logic [31:0]      value_r      [DEPTH];
    logic             taken_r      [DEPTH];

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;
    logic [TAG_W:0]   count_next_s;

    logic             full_s;
    logic             alloc_s;
    logic             cdb_hit_s;
    logic             commit_s;

    assign full_s    = (count_r == DEPTH_C);
    assign alloc_s   = alloc_valid && !full_s;
    assign cdb_hit_s = cdb_valid && busy_r[cdb_tag];
    assign commit_s  = busy_r[head_r] && ready_r[head_r];

    assign ROB_entry = tail_r;
    assign full      = full_s;
    assign count     = count_r;

    // Occupancy next value: simultaneous alloc and commit cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({alloc_s, commit_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and busy/ready flags; a flush wipes everything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i]  <= 1'b0;
                ready_r[i] <= 1'b0;
            end
        end else if (mispredicted) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                busy_r[i]  <= 1'b0;
                ready_r[i] <= 1'b0;
            end
        end else begin
            if (alloc_s) begin
                busy_r[tail_r]  <= 1'b1;
                ready_r[tail_r] <= 1'b0;
                tail_r          <= tail_r + TAG_ONE;
            end
            if (cdb_hit_s) begin
                ready_r[cdb_tag] <= 1'b1;
            end
            // Commit is last so it wins over a late CDB write to the retiring head.
            if (commit_s) begin
                busy_r[head_r]  <= 1'b0;
                ready_r[head_r] <= 1'b0;
                head_r          <= head_r + TAG_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Entry payload; only observed through a busy+ready head, so no reset needed.
    always_ff @(posedge clk) begin
        if (alloc_s && !mispredicted) begin
            writes_r[tail_r]     <= alloc_writes;
            dest_r[tail_r]       <= alloc_dest;
            is_branch_r[tail_r]  <= alloc_is_branch;
            pc_r[tail_r]         <= alloc_pc;
            imm_se_r[tail_r]     <= alloc_imm_se;
            pred_taken_r[tail_r] <= alloc_pred_taken;
        end
        if (cdb_hit_s && !mispredicted) begin
            value_r[cdb_tag] <= cdb_value;
            taken_r[cdb_tag] <= cdb_taken;
        end
    end

    // Commit port: driven from the head entry while it is ready, zero otherwise.
    always_comb begin
        if (commit_s) begin
            valid_in            = 1'b1;
            RegWrite            = writes_r[head_r] && !is_branch_r[head_r];
            rd                  = dest_r[head_r];
            WriteData           = value_r[head_r];
            commit_tag          = head_r;
            committed_is_branch = is_branch_r[head_r];
            committed_pc        = pc_r[head_r];
            commit_imm_se       = imm_se_r[head_r];
            commit_taken        = taken_r[head_r];
            commit_result       = (taken_r[head_r] == pred_taken_r[head_r]);
        end else begin
            valid_in            = 1'b0;
            RegWrite            = 1'b0;
            rd                  = 5'd0;
            WriteData           = 32'd0;
            commit_tag          = '0;
            committed_is_branch = 1'b0;
            committed_pc        = 32'd0;
            commit_imm_se       = 32'd0;
            commit_taken        = 1'b0;
            commit_result       = 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model checked
// every cycle, plus hand-computed literal checks at the interesting points.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_writes, alloc_is_branch, alloc_pred_taken;
    logic [4:0]  alloc_dest;
    logic [31:0] alloc_pc, alloc_imm_se;
    logic [2:0]  ROB_entry;
    logic        full;
    logic        cdb_valid, cdb_taken;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        mispredicted;
    logic [3:0]  count;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] WriteData;
    logic [2:0]  commit_tag;
    logic        valid_in, committed_is_branch, commit_taken, commit_result;
    logic [31:0] committed_pc, commit_imm_se;

    int n_cmp = 0;
    int n_bad = 0;

    reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_writes(alloc_writes), .alloc_dest(alloc_dest),
        .alloc_is_branch(alloc_is_branch), .alloc_pc(alloc_pc), .alloc_imm_se(alloc_imm_se),
        .alloc_pred_taken(alloc_pred_taken), .ROB_entry(ROB_entry), .full(full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .mispredicted(mispredicted), .count(count),
        .RegWrite(RegWrite), .rd(rd), .WriteData(WriteData), .commit_tag(commit_tag),
        .valid_in(valid_in), .committed_is_branch(committed_is_branch),
        .committed_pc(committed_pc), .commit_imm_se(commit_imm_se),
        .commit_taken(commit_taken), .commit_result(commit_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Program-order model: queue of live tags, per-tag records, next tag to grant.
    int          mq[$];
    int          m_tail = 0;
    bit          m_rdy [8];
    bit          m_wr  [8];
    bit          m_br  [8];
    bit          m_pt  [8];
    bit          m_tk  [8];
    logic [4:0]  m_dst [8];
    logic [31:0] m_pc  [8];
    logic [31:0] m_imm [8];
    logic [31:0] m_val [8];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_tail = 0;
        end else if (mispredicted) begin
            mq.delete();
            m_tail = 0;
        end else begin
            bit c, a;
            c = (mq.size() > 0) && m_rdy[mq[0]];
            a = alloc_valid && (mq.size() < 8);
            if (cdb_valid) begin
                foreach (mq[k]) begin
                    if (mq[k] == int'(cdb_tag)) begin
                        m_val[mq[k]] = cdb_value;
                        m_tk[mq[k]]  = cdb_taken;
                        m_rdy[mq[k]] = 1'b1;
                    end
                end
            end
            if (c) void'(mq.pop_front());
            if (a) begin
                m_wr[m_tail]  = alloc_writes;
                m_dst[m_tail] = alloc_dest;
                m_br[m_tail]  = alloc_is_branch;
                m_pc[m_tail]  = alloc_pc;
                m_imm[m_tail] = alloc_imm_se;
                m_pt[m_tail]  = alloc_pred_taken;
                m_rdy[m_tail] = 1'b0;
                mq.push_back(m_tail);
                m_tail = (m_tail + 1) % 8;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [107:0] exp_c, act_c;
        bit           ec;
        int           h;
        ec = (mq.size() > 0) && m_rdy[mq[0]];
        exp_c = '0;
        if (ec) begin
            h = mq[0];
            exp_c = {m_wr[h] && !m_br[h], m_dst[h], m_val[h], 3'(h), m_br[h],
                     m_pc[h], m_imm[h], m_tk[h], m_tk[h] == m_pt[h]};
        end
        act_c = {RegWrite, rd, WriteData, commit_tag, committed_is_branch,
                 committed_pc, commit_imm_se, commit_taken, commit_result};
        chk("model_count", 128'(count), 128'(mq.size()));
        chk("model_full", 128'(full), 128'(mq.size() == 8));
        chk("model_rob_entry", 128'(ROB_entry), 128'(m_tail));
        chk("model_valid_in", 128'(valid_in), 128'(ec));
        chk("model_commit_bus", 128'(act_c), 128'(exp_c));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_writes = 1'b0; alloc_dest = 5'd0; alloc_is_branch = 1'b0;
        alloc_pc = 32'd0; alloc_imm_se = 32'd0; alloc_pred_taken = 1'b0;
        cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_value = 32'd0; cdb_taken = 1'b0;
        mispredicted = 1'b0;
    endtask

    task automatic alloc(input logic wr, input logic [4:0] dst, input logic br,
                         input logic [31:0] pc, input logic [31:0] imm, input logic pt);
        idle();
        alloc_valid = 1'b1; alloc_writes = wr; alloc_dest = dst; alloc_is_branch = br;
        alloc_pc = pc; alloc_imm_se = imm; alloc_pred_taken = pt;
    endtask

    task automatic cdb(input logic [2:0] tag, input logic [31:0] val, input logic tk);
        idle();
        cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val; cdb_taken = tk;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_rob_entry", 128'(ROB_entry), 128'(0));
        chk("rst_valid_in", 128'(valid_in), 128'(0));
        reset = 1'b0;
        step();

        // Fill: tags 0..7, then a ninth alloc is ignored.
        for (int i = 0; i < 8; i++) begin
            chk("fill_tag", 128'(ROB_entry), 128'(i));
            alloc(1'b1, 5'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0);
            step();
        end
        chk("fill_full", 128'(full), 128'(1));
        chk("fill_count", 128'(count), 128'(8));
        alloc(1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("ninth_count", 128'(count), 128'(8));
        chk("ninth_rob_entry", 128'(ROB_entry), 128'(0));

        // Out-of-order completion, in-order commit; alloc refused while full.
        cdb(3'd1, 32'h22, 1'b0); step();
        cdb(3'd0, 32'h11, 1'b0); step();
        chk("c0_valid_in", 128'(valid_in), 128'(1));
        chk("c0_rd", 128'(rd), 128'(1));
        chk("c0_wdata", 128'(WriteData), 128'(32'h11));
        chk("c0_regwrite", 128'(RegWrite), 128'(1));
        alloc(1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("full_commit_count", 128'(count), 128'(7));
        chk("full_commit_tag", 128'(ROB_entry), 128'(0));
        chk("c1_rd", 128'(rd), 128'(2));
        chk("c1_wdata", 128'(WriteData), 128'(32'h22));
        alloc(1'b1, 5'd10, 1'b0, 32'd0, 32'd0, 1'b0);
        step();
        chk("wrap_count", 128'(count), 128'(7));
        chk("wrap_rob_entry", 128'(ROB_entry), 128'(1));
        chk("wrap_no_commit", 128'(valid_in), 128'(0));
        idle();

        // Flush, then flush again with same-cycle alloc and CDB.
        mispredicted = 1'b1; step(); idle();
        chk("flush_count", 128'(count), 128'(0));
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 5'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0);
            step();
        end
        alloc(1'b1, 5'd4, 1'b0, 32'd0, 32'd0, 1'b0);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 32'd5;
        mispredicted = 1'b1;
        step(); idle();
        chk("mp_count", 128'(count), 128'(0));
        chk("mp_rob_entry", 128'(ROB_entry), 128'(0));
        chk("mp_no_commit", 128'(valid_in), 128'(0));
        step();
        chk("mp_no_commit2", 128'(valid_in), 128'(0));

        // CDB to a free entry is ignored.
        cdb(3'd0, 32'h99, 1'b0); step();
        alloc(1'b1, 5'd7, 1'b0, 32'd0, 32'd0, 1'b0); step(); idle();
        step();
        chk("stale_cdb_no_commit", 128'(valid_in), 128'(0));
        cdb(3'd0, 32'h77, 1'b0); step(); idle();
        chk("late_wdata", 128'(WriteData), 128'(32'h77));
        chk("late_rd", 128'(rd), 128'(7));
        step();

        // Mispredicted branch commit.
        alloc(1'b1, 5'd3, 1'b1, 32'h40, 32'h10, 1'b0); step();
        cdb(3'd1, 32'h44, 1'b1); step(); idle();
        chk("br_valid_in", 128'(valid_in), 128'(1));
        chk("br_is_branch", 128'(committed_is_branch), 128'(1));
        chk("br_regwrite", 128'(RegWrite), 128'(0));
        chk("br_taken", 128'(commit_taken), 128'(1));
        chk("br_result", 128'(commit_result), 128'(0));
        chk("br_pc", 128'(committed_pc), 128'(32'h40));
        chk("br_imm", 128'(commit_imm_se), 128'(32'h10));
        step();

        // Correctly predicted branch.
        alloc(1'b0, 5'd0, 1'b1, 32'h80, 32'hFFFF_FFF0, 1'b1); step();
        cdb(3'd2, 32'd0, 1'b1); step(); idle();
        chk("br2_result", 128'(commit_result), 128'(1));
        chk("br2_imm", 128'(commit_imm_se), 128'(32'hFFFF_FFF0));
        step();

        // Flush during the branch commit discards a ready younger entry.
        alloc(1'b0, 5'd0, 1'b1, 32'hC0, 32'h4, 1'b0); step();
        alloc(1'b1, 5'd5, 1'b0, 32'd0, 32'd0, 1'b0); step();
        cdb(3'd4, 32'h55, 1'b0); step();
        cdb(3'd3, 32'd0, 1'b1); step(); idle();
        chk("br3_valid_in", 128'(valid_in), 128'(1));
        chk("br3_tag", 128'(commit_tag), 128'(3));
        mispredicted = 1'b1; step(); idle();
        chk("br3_flush_count", 128'(count), 128'(0));
        chk("br3_flush_no_commit", 128'(valid_in), 128'(0));

        // Asynchronous reset with five entries in flight.
        for (int i = 0; i < 5; i++) begin
            alloc(1'b1, 5'(i + 1), 1'b0, 32'd0, 32'd0, 1'b0);
            step();
        end
        cdb(3'd0, 32'hAB, 1'b0); step(); idle();
        chk("pre_rst_valid_in", 128'(valid_in), 128'(1));
        chk("pre_rst_count", 128'(count), 128'(5));
        #1 reset = 1'b1;
        #1;
        chk("async_rst_valid_in", 128'(valid_in), 128'(0));
        chk("async_rst_count", 128'(count), 128'(0));
        chk("async_rst_wdata", 128'(WriteData), 128'(0));
        chk("async_rst_rob_entry", 128'(ROB_entry), 128'(0));
        step();
        reset = 1'b0;
        step();
        chk("post_rst_valid_in", 128'(valid_in), 128'(0));
        chk("post_rst_count", 128'(count), 128'(0));
        alloc(1'b1, 5'd1, 1'b0, 32'd0, 32'd0, 1'b0); step(); idle();
        chk("post_rst_alloc_count", 128'(count), 128'(1));
        chk("post_rst_alloc_tag", 128'(ROB_entry), 128'(1));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 8, number of ROB entries (power of two).
REQ-002 SHALL have parameter TAG_W, 3, entry tag width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alloc_valid  input  1  issue stage allocates one entry this cycle.
REQ-006 SHALL have ports alloc_writes (input, 1), alloc_dest (input, 5) and alloc_is_branch (input, 1): entry writes the regfile, destination register, entry is a branch.
REQ-007 SHALL have ports alloc_pc (input, 32), alloc_imm_se (input, 32) and alloc_pred_taken (input, 1): branch PC, sign-extended immediate, predicted direction.
REQ-008 SHALL have ports ROB_entry (output, TAG_W) and full (output, 1): tag granted to the next allocation, and no free entry.
REQ-009 SHALL have ports cdb_valid (input, 1), cdb_tag (input, TAG_W), cdb_value (input, 32) and cdb_taken (input, 1): CDB broadcast and the branch outcome.
REQ-010 SHALL have ports mispredicted (input, 1): flush request; count (output, TAG_W+1): occupancy.
REQ-011 SHALL have ports RegWrite (output, 1), rd (output, 5), WriteData (output, 32) and commit_tag (output, TAG_W): regfile/regstat commit.
REQ-012 SHALL have ports valid_in (output, 1), committed_is_branch (output, 1), committed_pc (output, 32), commit_imm_se (output, 32), commit_taken (output, 1) and commit_result (output, 1): commit pulse, branch flag, branch info, actual outcome, prediction correct.

Function
REQ-013 SHALL store per entry: busy, ready, writes, dest, is_branch, pc, imm_se, pred_taken, value, taken; circular buffer with head, tail (TAG_W bits each) and count (TAG_W+1 bits).
REQ-014 SHALL drive ROB_entry = tail combinationally; full = (count == DEPTH).
REQ-015 SHALL allocate when alloc_valid && !full: entry[tail] gets busy=1, ready=0 and the alloc fields; tail wraps modulo DEPTH (7 -> 0).
REQ-016 SHALL ignore alloc_valid while full (no state change, no error).
REQ-017 SHALL capture on cdb_valid with entry[cdb_tag].busy: value=cdb_value, taken=cdb_taken, ready=1; ignore cdb to non-busy entries.
REQ-018 SHALL fire commit (valid_in=1) combinationally when entry[head].busy && ready; one commit per cycle maximum.
REQ-019 SHALL on commit drive RegWrite=writes && !is_branch, rd=dest, WriteData=value, commit_tag=head, committed_is_branch=is_branch, committed_pc=pc, commit_imm_se=imm_se, commit_taken=taken, commit_result=(taken == pred_taken).
REQ-020 SHALL hold all commit outputs at 0 when no commit fires.
REQ-021 SHALL at the edge ending a commit cycle clear entry[head].busy and advance head modulo DEPTH.
REQ-022 SHALL update count as +1 for alloc only, -1 for commit only, unchanged for both; full is evaluated on the registered count, so alloc is refused in a full cycle even if a commit also fires.
REQ-023 SHALL give a result written by the CDB in cycle N to the head its commit in cycle N+1 at the earliest (ready is registered; no CDB-to-commit bypass).
REQ-024 SHALL on mispredicted=1 at a clock edge clear every busy/ready bit, set head=tail=count=0, and discard same-cycle alloc and CDB writes; the commit presented that cycle (the mispredicting branch) remains valid.
REQ-025 SHALL give flush priority over alloc, CDB and commit state updates.

Reset
REQ-026 SHALL on reset asynchronously clear head, tail, count and all busy/ready bits, making full=0, ROB_entry=0 and all commit outputs 0 while reset is high.
REQ-027 SHALL discard in-flight entries when reset asserts mid-operation, with no commit on the first edge after release.

Verification
REQ-028 SHALL cover: 8 allocs (dest=1..8, writes=1) -> tags 0..7, full=1 after 8th; 9th alloc ignored, count=8.
REQ-029 SHALL cover: CDB tag 1 value 0x22, then tag 0 value 0x11 -> commits in order: cycle after tag-0 write rd=1 WriteData=0x11, next cycle rd=2 WriteData=0x22.
REQ-030 SHALL cover: branch alloc pred_taken=0, pc=0x40, imm=0x10; CDB taken=1 -> commit valid_in=1, committed_is_branch=1, RegWrite=0, commit_taken=1, commit_result=0.
REQ-031 SHALL cover: 3 entries busy, mispredicted=1 with same-cycle alloc and CDB -> next cycle count=0, ROB_entry=0, no commit.
REQ-032 SHALL cover: full buffer, head ready, alloc_valid=1 -> commit fires, alloc refused, count=7; next cycle alloc gets tag 0 (wrap).
REQ-033 SHALL cover: reset asserted mid-cycle with 5 entries -> outputs 0 immediately, count=0 after release.
